// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one EXE-stage ALU between two requesters.
// Operands are registered toward the ALU and the result is registered into a tagged response.
//
// state | meaning
// IDLE  | waiting for a request; ready is driven only to the granted requester
// EXEC  | registered operands are stable at the ALU; result captured at end of cycle
// RESP  | response held on rsp_* until rsp_ready
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_val1,
    input  logic [DATA_W-1:0] req0_val2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_val1,
    input  logic [DATA_W-1:0] req1_val2,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_val1,
    output logic [DATA_W-1:0] alu_val2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   grant_id;
    logic   grant0;
    logic   grant1;

    // Ready is gated by rst_n so nothing is ever accepted while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            grant_id   <= 1'b0;
            alu_cmd    <= '0;
            alu_val1   <= '0;
            alu_val2   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_cmd  <= grant1 ? req1_cmd  : req0_cmd;
                        alu_val1 <= grant1 ? req1_val1 : req0_val1;
                        alu_val2 <= grant1 ? req1_val2 : req0_val2;
                        grant_id <= grant1;
                        prio     <= grant0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= grant_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
